axi_burst_writer: RTL and testbench

AXI4 write-burst master feeding the mst_s (initiator) slave port of pci_axi_top, so local logic can push word streams into PCI host memory. Accepts a command (host address, word count) plus a 32-bit data stream. Splits the transfer into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary. Reports completion and any error response.

---
 rtl/axi_defs_pkg.sv | 26 ++
 rtl/axi_burst_len_calc.sv | 32 +++
 rtl/axi_burst_writer.sv | 160 ++++++++++++++++
 tb/tb_axi_burst_writer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_defs_pkg.sv
// Shared AXI4 encodings and burst-writer FSM state encoding.
package axi_defs_pkg;

  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Beat counts run up to 256, so one bit wider than awlen.
  localparam int BEATS_W = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA,
    S_RESP = ST_RESP,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beats for the next burst: the smallest of words remaining, MAX_BURST and
// words left before the next 4 KB boundary.
module axi_burst_len_calc
  import axi_defs_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic [11:0]          i_addrLow,
  input  logic [LEN_WIDTH-1:0] i_remaining,
  output logic [BEATS_W-1:0]   o_beats
);

  localparam int CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

  logic [CW-1:0] w_toBoundary;
  logic [CW-1:0] w_remaining;
  logic [CW-1:0] w_maxBurst;
  logic [CW-1:0] w_min1;
  logic [CW-1:0] w_min2;
  logic          w_unusedAddr;

  // Words to the boundary lie in 1..1024, so 11 bits always suffice.
  assign w_toBoundary = CW'(11'd1024 - {1'b0, i_addrLow[11:2]});
  assign w_remaining  = CW'(i_remaining);
  assign w_maxBurst   = CW'(MAX_BURST);
  assign w_min1       = (w_remaining < w_maxBurst) ? w_remaining : w_maxBurst;
  assign w_min2       = (w_min1 < w_toBoundary) ? w_min1 : w_toBoundary;
  assign o_beats      = BEATS_W'(w_min2);
  assign w_unusedAddr = ^i_addrLow[1:0];

endmodule

// File: rtl/axi_burst_writer.sv
// AXI4 write-burst master: splits a (host address, word count) command plus a
// 32-bit word stream into 4 KB-safe INCR bursts, one burst outstanding.
module axi_burst_writer
  import axi_defs_pkg::*;
#(
  parameter logic [3:0] AXI_ID    = 4'd0,
  parameter int         MAX_BURST = 16,
  parameter int         LEN_WIDTH = 16
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_aresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [63:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 s_data_valid,
  output logic                 s_data_ready,
  input  logic [31:0]          s_data,
  output logic [3:0]           m_axi_awid,
  output logic [63:0]          m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic [3:0]           m_axi_awcache,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [3:0]           m_axi_wid,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [3:0]           m_axi_bid,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic                 done_valid,
  output logic                 done_error
);

  state_t               r_state;
  state_t               w_nextState;
  logic [63:0]          r_addr;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [BEATS_W-1:0]   r_beats;
  logic [BEATS_W-1:0]   r_beatCnt;
  logic                 r_err;

  logic                 w_beatFire;
  logic                 w_lastBeat;
  logic                 w_bFire;
  logic [63:0]          w_nextAddr;
  logic [LEN_WIDTH-1:0] w_nextRem;
  logic [11:0]          w_calcAddr;
  logic [LEN_WIDTH-1:0] w_calcRem;
  logic [BEATS_W-1:0]   w_calcBeats;
  logic                 w_unusedInputs;

  assign w_beatFire = (r_state == S_DATA) && s_data_valid && m_axi_wready;
  assign w_lastBeat = (r_beatCnt == (r_beats - 1'b1));
  assign w_bFire    = (r_state == S_RESP) && m_axi_bvalid;
  assign w_nextAddr = r_addr + {53'd0, r_beats, 2'b00};
  assign w_nextRem  = r_remaining - LEN_WIDTH'(r_beats);

  // Burst size is computed from the values about to be latched, so it is
  // already registered when ADDR is entered.
  assign w_calcAddr = (r_state == S_IDLE) ? {cmd_addr[11:2], 2'b00} : w_nextAddr[11:0];
  assign w_calcRem  = (r_state == S_IDLE) ? cmd_len : w_nextRem;

  axi_burst_len_calc #(
    .MAX_BURST (MAX_BURST),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_lenCalc (
    .i_addrLow   (w_calcAddr),
    .i_remaining (w_calcRem),
    .o_beats     (w_calcBeats)
  );

  assign m_axi_awid     = AXI_ID;
  assign m_axi_awaddr   = r_addr;
  assign m_axi_awlen    = 8'(r_beats - 1'b1);
  assign m_axi_awsize   = AXI_SIZE_4B;
  assign m_axi_awburst  = AXI_BURST_INCR;
  assign m_axi_awcache  = 4'h0;
  assign m_axi_wid      = AXI_ID;
  assign m_axi_wdata    = s_data;
  assign m_axi_wstrb    = 4'hF;
  assign w_unusedInputs = ^{m_axi_bid, cmd_addr[1:0]};

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_beatCnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_addr      <= {cmd_addr[63:2], 2'b00};
          r_remaining <= cmd_len;
          r_beats     <= w_calcBeats;
          r_err       <= 1'b0;
        end
        S_ADDR: if (m_axi_awready) r_beatCnt <= '0;
        S_DATA: if (w_beatFire) r_beatCnt <= r_beatCnt + 1'b1;
        // An error response is recorded but the remaining bursts still go out.
        S_RESP: if (w_bFire) begin
          if (m_axi_bresp != AXI_RESP_OKAY) r_err <= 1'b1;
          r_addr      <= w_nextAddr;
          r_remaining <= w_nextRem;
          r_beats     <= w_calcBeats;
        end
        default: ;
      endcase
    end
  end

  // cmd_ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    w_nextState   = r_state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_data_ready  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    done_valid    = 1'b0;
    done_error    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = m_axi_aresetn;
        if (cmd_valid) w_nextState = (cmd_len == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_nextState = S_DATA;
      end
      S_DATA: begin
        m_axi_wvalid = s_data_valid;
        s_data_ready = m_axi_wready;
        m_axi_wlast  = w_lastBeat;
        if (w_beatFire && w_lastBeat) w_nextState = S_RESP;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_nextState = (w_nextRem == '0) ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        done_valid  = 1'b1;
        done_error  = r_err;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: table of commands with hand-computed
// burst splits, an AXI slave/stream model, plus reset corner sequences.
module tb_axi_burst_writer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        s_data_valid = 1'b0;
  logic        s_data_ready;
  logic [31:0] s_data = '0;
  logic [3:0]  awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [3:0]  bid = 4'd0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        done_valid;
  logic        done_error;

  axi_burst_writer dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .s_data_valid  (s_data_valid),
    .s_data_ready  (s_data_ready),
    .s_data        (s_data),
    .m_axi_awid    (awid),
    .m_axi_awaddr  (awaddr),
    .m_axi_awlen   (awlen),
    .m_axi_awsize  (awsize),
    .m_axi_awburst (awburst),
    .m_axi_awcache (awcache),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wid     (wid),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wlast   (wlast),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bid     (bid),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .done_valid    (done_valid),
    .done_error    (done_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      addr;
    int               len;
    int               errBurst;
    bit               gaps;
    int               nBursts;
    logic [2:0][63:0] expAddr;
    logic [2:0][7:0]  expLen;
    bit               expErr;
  } vec_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic        ok;
  } aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        ok;
  } w_t;

  vec_t vecs[9];
  aw_t  awQ[$];
  w_t   wQ[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Owned by the main initial block.
  bit gaps = 1'b0;
  int dataLimit = 0;
  int errAbs = -1;

  // Owned by the driver block.
  int idx = 0;
  int pendingB = 0;
  int bCount = 0;

  // Owned by the negedge monitor.
  bit dataFire = 1'b0;
  bit wLastFire = 1'b0;
  bit bFire = 1'b0;
  bit awSeen = 1'b0;
  int acceptCount = 0;
  int acceptCycle = 0;
  int firstAwCycle = -1;
  int doneCount = 0;
  int doneCycle = 0;
  bit doneErr = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Stream source and AXI slave responses, driven just after each edge.
  always @(posedge clk) begin
    #1;
    if (dataFire) idx++;
    if (wLastFire) pendingB++;
    if (bFire) begin
      pendingB--;
      bCount++;
      bvalid = 1'b0;
    end
    s_data_valid = (idx < dataLimit) && (!gaps || $urandom_range(0, 3) != 0);
    s_data = 32'hA500_0000 + idx;
    awready = !gaps || ($urandom_range(0, 2) != 0);
    wready = !gaps || ($urandom_range(0, 2) != 0);
    if (!bvalid && pendingB > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
      bvalid = 1'b1;
      bresp = (bCount == errAbs) ? 2'b10 : 2'b00;
    end
  end

  // Handshakes are recorded on the falling edge, ahead of the edge that takes them.
  always @(negedge clk) begin
    dataFire = s_data_valid && s_data_ready;
    wLastFire = wvalid && wready && wlast;
    bFire = bvalid && bready;
    if (cmd_valid && cmd_ready) begin
      acceptCount++;
      acceptCycle = cycle;
      awSeen = 1'b0;
      firstAwCycle = -1;
    end
    if (awvalid && !awSeen) begin
      awSeen = 1'b1;
      firstAwCycle = cycle;
    end
    if (awvalid && awready)
      awQ.push_back('{addr: awaddr, len: awlen,
                      ok: (awid == 4'd0) && (awsize == 3'b010) && (awburst == 2'b01) && (awcache == 4'd0)});
    if (wvalid && wready)
      wQ.push_back('{data: wdata, last: wlast,
                     ok: (wid == 4'd0) && (wstrb == 4'hF) && (wdata == s_data)});
    if (done_valid) begin
      doneCount++;
      doneCycle = cycle;
      doneErr = done_error;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int v, input logic [63:0] addr, input int len, input int errBurst,
                        input bit g, input int nB, input logic [63:0] a0, input int l0,
                        input logic [63:0] a1, input int l1, input logic [63:0] a2, input int l2,
                        input bit expErr);
    vecs[v].addr = addr;
    vecs[v].len = len;
    vecs[v].errBurst = errBurst;
    vecs[v].gaps = g;
    vecs[v].nBursts = nB;
    vecs[v].expAddr[0] = a0;
    vecs[v].expAddr[1] = a1;
    vecs[v].expAddr[2] = a2;
    vecs[v].expLen[0] = 8'(l0);
    vecs[v].expLen[1] = 8'(l1);
    vecs[v].expLen[2] = 8'(l2);
    vecs[v].expErr = expErr;
  endtask

  task automatic issueCmd(input logic [63:0] addr, input int len, output bit ok);
    int accStart;
    accStart = acceptCount;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = addr;
    cmd_len = 16'(len);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (acceptCount > accStart) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int v);
    int startIdx, awStart, wStart, doneStart, wi, beats;
    bit ok, seenDone;
    string tag;
    tag = $sformatf("vec%0d", v);
    gaps = vecs[v].gaps;
    startIdx = idx;
    dataLimit = idx + vecs[v].len;
    errAbs = (vecs[v].errBurst < 0) ? -1 : bCount + vecs[v].errBurst;
    awStart = awQ.size();
    wStart = wQ.size();
    doneStart = doneCount;
    issueCmd(vecs[v].addr, vecs[v].len, ok);
    checkOutput({tag, " accept"}, 64'(ok), 64'd1);
    seenDone = 1'b0;
    for (int c = 0; c < 3000 && ok; c++) begin
      @(posedge clk);
      if (doneCount > doneStart) begin
        seenDone = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    checkOutput({tag, " done seen"}, 64'(seenDone), 64'd1);
    checkOutput({tag, " done pulses"}, 64'(doneCount - doneStart), 64'd1);
    checkOutput({tag, " done_error"}, 64'(doneErr), 64'(vecs[v].expErr));
    if (vecs[v].len == 0)
      checkOutput({tag, " done latency"}, 64'(doneCycle - acceptCycle), 64'd1);
    else
      checkOutput({tag, " awvalid latency"}, 64'(firstAwCycle - acceptCycle), 64'd1);
    checkOutput({tag, " burst count"}, 64'(awQ.size() - awStart), 64'(vecs[v].nBursts));
    beats = 0;
    for (int b = 0; b < vecs[v].nBursts; b++) beats += int'(vecs[v].expLen[b]) + 1;
    checkOutput({tag, " beat count"}, 64'(wQ.size() - wStart), 64'(beats));
    wi = wStart;
    for (int b = 0; b < vecs[v].nBursts && awStart + b < awQ.size(); b++) begin
      checkOutput($sformatf("%s awaddr%0d", tag, b), awQ[awStart + b].addr, vecs[v].expAddr[b]);
      checkOutput($sformatf("%s awlen%0d", tag, b), 64'(awQ[awStart + b].len), 64'(vecs[v].expLen[b]));
      checkOutput($sformatf("%s awconst%0d", tag, b), 64'(awQ[awStart + b].ok), 64'd1);
      for (int k = 0; k <= int'(vecs[v].expLen[b]) && wi < wQ.size(); k++) begin
        checkOutput($sformatf("%s wdata%0d", tag, wi - wStart), 64'(wQ[wi].data),
                    64'(32'hA500_0000 + 32'(startIdx + wi - wStart)));
        checkOutput($sformatf("%s wlast%0d", tag, wi - wStart), 64'(wQ[wi].last),
                    64'(k == int'(vecs[v].expLen[b])));
        checkOutput($sformatf("%s wconst%0d", tag, wi - wStart), 64'(wQ[wi].ok), 64'd1);
        wi++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wStart, doneStart;
    bit ok, seenBeat;

    setVec(0, 64'hE000_0000, 1, -1, 0, 1, 64'hE000_0000, 0, 0, 0, 0, 0, 0);
    setVec(1, 64'hE000_0000, 40, -1, 0, 3, 64'hE000_0000, 15, 64'hE000_0040, 15, 64'hE000_0080, 7, 0);
    setVec(2, 64'hE000_0FF0, 8, -1, 0, 2, 64'hE000_0FF0, 3, 64'hE000_1000, 3, 0, 0, 0);
    setVec(3, 64'hE000_0000, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setVec(4, 64'hE000_0000, 40, 1, 0, 3, 64'hE000_0000, 15, 64'hE000_0040, 15, 64'hE000_0080, 7, 1);
    setVec(5, 64'hE000_0000, 40, -1, 0, 3, 64'hE000_0000, 15, 64'hE000_0040, 15, 64'hE000_0080, 7, 0);
    setVec(6, 64'h1_2345_6FE3, 20, -1, 1, 2, 64'h1_2345_6FE0, 7, 64'h1_2345_7000, 11, 0, 0, 0);
    setVec(7, 64'hE000_0000, 40, 2, 1, 3, 64'hE000_0000, 15, 64'hE000_0040, 15, 64'hE000_0080, 7, 1);
    setVec(8, 64'h0000_0000_FFFF_FFF8, 4, -1, 1, 2, 64'h0000_0000_FFFF_FFF8, 1, 64'h1_0000_0000, 1, 0, 0, 0);

    // Outputs while reset is held, then cmd_ready once it is released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("reset valids", 64'({awvalid, wvalid, bready, done_valid, done_error, wlast}), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk);
    checkOutput("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

    for (int v = 0; v < 9; v++) applyStimulus(v);

    // Reset in the middle of a data burst abandons it without a completion.
    gaps = 1'b0;
    dataLimit = idx + 16;
    wStart = wQ.size();
    doneStart = doneCount;
    issueCmd(64'hE000_0000, 16, ok);
    checkOutput("midreset accept", 64'(ok), 64'd1);
    seenBeat = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (wQ.size() > wStart) begin
        seenBeat = 1'b1;
        break;
      end
    end
    checkOutput("midreset beat seen", 64'(seenBeat), 64'd1);
    #1;
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset valids", 64'({awvalid, wvalid, bready, done_valid, wlast, s_data_ready}), 64'd0);
    checkOutput("midreset cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk);
    checkOutput("midreset cmd_ready after", 64'(cmd_ready), 64'd1);
    repeat (5) @(posedge clk);
    checkOutput("midreset no done", 64'(doneCount - doneStart), 64'd0);

    applyStimulus(0);
    applyStimulus(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
